mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of execute. Consumes the EX/MEM register outputs: ALU result/address,
//  store data, control and debug fields. Runs a request/response handshake to the data memory, aligns loads and
//  lane-masks stores. Drives o_data_busy back to fetch/decode/execute to stall them. Owns the MEM/WB register.
// PARAMETERS
//  RST_INST    32'h00000033  o_inst value held in MEM/WB after reset (add x0,x0,x0)
//  TMO_CYCLES  64            cycles in REQ+WAIT before a memory access is aborted (>=2)
// PORTS
//  i_clk           in   1   clock
//  i_rst_n         in   1   asynchronous, active-low reset
//  i_vld           in   1   EX/MEM entry valid
//  i_mem_read      in   1   load
//  i_mem_write     in   1   store
//  i_opsel         in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_res           in   32  ALU result; the byte address for memory ops
//  i_wdata         in   32  store data (rs2)
//  i_rd_waddr      in   5   destination register
//  i_rd_wen        in   1   destination write enable
//  i_inst,i_pc,i_nxt_pc in 32 each  debug/retire fields, passed through
//  i_break         in   1   ebreak marker, passed through
//  o_dmem_req      out  1   request valid
//  o_dmem_wen      out  1   1 = store
//  o_dmem_addr     out  32  word address {i_res[31:2],2'b00}
//  o_dmem_wdata    out  32  lane-replicated store data
//  o_dmem_mask     out  4   byte strobes
//  i_dmem_ready    in   1   request accepted this cycle
//  i_dmem_rvalid   in   1   load data valid
//  i_dmem_rdata    in   32  load data
//  o_data_busy     out  1   stall upstream; inputs are held stable while high
//  o_vld,o_rd_waddr,o_rd_wen,o_inst,o_pc,o_nxt_pc,o_break  out  MEM/WB register outputs
//  o_rd_wdata      out  32  writeback data: aligned load data or i_res
//  o_dmem_err      out  1   one-cycle pulse: access timed out
//  o_misaligned    out  1   MEM/WB flag; only active with MEM_MISALIGN_CHK_EN
// BEHAVIOUR
//  Reset values
//  - Resets on the async assert of i_rst_n; state IDLE, timeout counter 0.
//  - o_vld=0, o_rd_wen=0, o_rd_waddr=0, o_rd_wdata=0, o_inst=RST_INST, o_pc/o_nxt_pc=0, o_break=0.
//  - o_dmem_req=0, o_dmem_err=0, o_misaligned=0.
//  FSM
//  - IDLE: a memory op is i_vld&(i_mem_read|i_mem_write). On one, go to REQ with o_data_busy=1.
//    Otherwise the MEM/WB register loads every cycle (o_rd_wdata=i_res).
//  - REQ: o_dmem_req=1, with addr/wen/mask/wdata driven from the held inputs. On i_dmem_ready:
//    - store: complete.
//    - load with i_dmem_rvalid in the same cycle: complete.
//    - load otherwise: go to WAIT.
//  - WAIT: o_dmem_req=0. On i_dmem_rvalid: complete.
//  - Complete: o_data_busy=0 that cycle. MEM/WB captures at that edge, then IDLE. An i_dmem_rvalid seen in IDLE is ignored.
//  - Busy is combinational: (IDLE & mem op) | (REQ|WAIT & !complete).
//  - Latency: a load with ready and rvalid one cycle apart stalls 2 cycles; a store with ready at once stalls 1.
//  Timeout
//  - The counter increments in REQ/WAIT and clears in IDLE.
//  - At TMO_CYCLES without completion: o_dmem_err pulses, MEM/WB captures with o_rd_wen=0, and the FSM goes to IDLE.
//  Stores
//  - SB: mask 4'b0001<<a[1:0], wdata {4{b}}.
//  - SH: mask 4'b0011<<{a[1],1'b0}, wdata {2{h}}.
//  - SW: mask 4'hF.
//  - Stores write o_rd_wen = i_rd_wen & 0 (no writeback).
//  Loads
//  - Byte lane a[1:0], half lane a[1].
//  - B/H sign-extend, BU/HU zero-extend, W passes through.
//  Flush
//  - i_vld=0 inputs pass through as a bubble with o_vld=0 and o_rd_wen=0, regardless of i_rd_wen.
//  Reset mid-access
//  - o_dmem_req drops immediately; the in-flight response is discarded.
// CONFIGURATION
//  MEM_MISALIGN_CHK_EN defined:
//  - H with a[0]=1, or W with a[1:0]!=0, issues no request; stall 1 cycle (IDLE busy, then complete).
//  - MEM/WB captures o_misaligned=1 and o_rd_wen=0.
//  MEM_MISALIGN_CHK_EN undefined:
//  - Low address bits are ignored beyond the lane selection above; o_misaligned is tied to 0.
// TESTING
//  - ALU op, i_res=32'h1234, rd=5, no mem op: next cycle o_rd_wdata=32'h1234, o_rd_wen=1, o_data_busy=0 throughout.
//  - LB from 0x103, rdata 32'h80FF_0000, ready at REQ, rvalid 1 cycle later:
//    o_dmem_addr=0x100, o_data_busy high 2 cycles, o_rd_wdata=32'hFFFF_FF80.
//  - LHU with ready & rvalid in the same REQ cycle, addr 0x2, rdata 32'hBEEF_0000: o_rd_wdata=32'h0000_BEEF.
//  - SB 8'hA5 to 0x6: o_dmem_mask=4'b0100, o_dmem_wdata=32'hA5A5_A5A5, o_dmem_wen=1, o_rd_wen=0.
//  - Load never answered: o_dmem_err pulses after exactly TMO_CYCLES, o_rd_wen=0, FSM in IDLE.
//    A late rvalid is ignored.
//  - i_rst_n low during WAIT: o_dmem_req=0, o_vld=0, o_inst=RST_INST at once.
//    With MEM_MISALIGN_CHK_EN, LW 0x2 gives o_misaligned=1 and no request.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between mem_stage (master) and the data memory (slave).
// The master drives the request fields (req, wen, addr, wdata, mask) and samples ready,
// rvalid and rdata. ready accepts a request in the cycle it is high; rvalid qualifies rdata.
interface mem_stage_if;
  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, wen, addr, wdata, mask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, wdata, mask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data-memory handshake, load alignment, store lane
// masking, upstream stall and the MEM/WB register.
// Optional feature macro: MEM_MISALIGN_CHK_EN. When it is defined, misaligned halfword or
// word accesses are trapped without touching memory and flagged in MEM/WB.
//
// state  | meaning
// S_IDLE | no access in flight; MEM/WB follows the EX/MEM inputs every cycle
// S_REQ  | request presented, waiting for ready
// S_WAIT | load accepted, waiting for rvalid
// S_MIS  | misaligned access trapped; completes without a request
module mem_stage #(
  parameter logic [31:0] RST_INST   = 32'h0000_0033,
  parameter int          TMO_CYCLES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vld,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [2:0]  i_opsel,
  input  logic [31:0] i_res,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_nxt_pc,
  input  logic        i_break,
  mem_stage_if.master dmem,
  output logic        o_data_busy,
  output logic        o_vld,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen,
  output logic [31:0] o_rd_wdata,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_break,
  output logic        o_dmem_err,
  output logic        o_misaligned
);

  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_MIS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        mem_op;
  logic        misal_op;
  logic [1:0]  a_lo;
  logic        req;
  logic        done;
  logic        tmo;
  logic        cnt_last;
  logic [3:0]  st_mask;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  logic        wb_load;
  logic        vld_q, rd_wen_q, break_q, err_q;
  logic [4:0]  rd_waddr_q;
  logic [31:0] rd_wdata_q, inst_q, pc_q, nxt_pc_q;
  logic        rd_wen_d;
  logic [31:0] rd_wdata_d;

  assign a_lo     = i_res[1:0];
  assign mem_op   = i_vld & (i_mem_read | i_mem_write);
  assign cnt_last = (cnt_q == CNT_LAST);

`ifdef MEM_MISALIGN_CHK_EN
  assign misal_op = ((i_opsel[1:0] == 2'b01) & a_lo[0]) |
                    ((i_opsel[1:0] == 2'b10) & (a_lo != 2'b00));
`else
  assign misal_op = 1'b0;
`endif

  // Store lane strobes and replicated store data, from the held EX/MEM inputs.
  always_comb begin
    st_mask  = 4'hF;
    st_wdata = i_wdata;
    case (i_opsel[1:0])
      2'b00: begin
        st_mask  = 4'b0001 << a_lo;
        st_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        st_mask  = 4'b0011 << {a_lo[1], 1'b0};
        st_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        st_mask  = 4'hF;
        st_wdata = i_wdata;
      end
    endcase
  end

  // Load lane selection and sign/zero extension of the returned word.
  always_comb begin
    ld_byte = 8'h00;
    case (a_lo)
      2'd0: ld_byte = dmem.rdata[7:0];
      2'd1: ld_byte = dmem.rdata[15:8];
      2'd2: ld_byte = dmem.rdata[23:16];
      default: ld_byte = dmem.rdata[31:24];
    endcase
    ld_half = a_lo[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    case (i_opsel)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = dmem.rdata;
    endcase
  end

  // Next-state, stall and request generation; a timeout ends the access like a completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    o_data_busy = 1'b0;
    req         = 1'b0;
    done        = 1'b0;
    tmo         = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (mem_op) begin
          o_data_busy = 1'b1;
          state_d     = misal_op ? S_MIS : S_REQ;
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (dmem.ready & (i_mem_write | dmem.rvalid)) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_last) begin
          tmo     = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          o_data_busy = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          state_d     = dmem.ready ? S_WAIT : S_REQ;
        end
      end
      S_WAIT: begin
        if (dmem.rvalid) begin
          done    = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_last) begin
          tmo     = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          o_data_busy = 1'b1;
          cnt_d       = cnt_q + 1'b1;
        end
      end
      default: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and access timeout counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem.req   = req;
  assign dmem.wen   = i_mem_write;
  assign dmem.addr  = {i_res[31:2], 2'b00};
  assign dmem.wdata = st_wdata;
  assign dmem.mask  = st_mask;

  // MEM/WB loads on every non-memory cycle in IDLE and at the end of any access.
  assign wb_load    = ((state_q == S_IDLE) & ~mem_op) | done | tmo;
  assign rd_wen_d   = i_vld & i_rd_wen & ~i_mem_write & ~tmo & (state_q != S_MIS);
  assign rd_wdata_d = (done & ~i_mem_write & (state_q != S_MIS)) ? ld_data : i_res;

  // MEM/WB register plus the one-cycle timeout error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q      <= 1'b0;
      rd_waddr_q <= 5'd0;
      rd_wen_q   <= 1'b0;
      rd_wdata_q <= 32'd0;
      inst_q     <= RST_INST;
      pc_q       <= 32'd0;
      nxt_pc_q   <= 32'd0;
      break_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= tmo;
      if (wb_load) begin
        vld_q      <= i_vld;
        rd_waddr_q <= i_rd_waddr;
        rd_wen_q   <= rd_wen_d;
        rd_wdata_q <= rd_wdata_d;
        inst_q     <= i_inst;
        pc_q       <= i_pc;
        nxt_pc_q   <= i_nxt_pc;
        break_q    <= i_break;
      end
    end
  end

`ifdef MEM_MISALIGN_CHK_EN
  logic mis_q;

  // Misalignment flag travels with the MEM/WB entry it belongs to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mis_q <= 1'b0;
    end else if (wb_load) begin
      mis_q <= (state_q == S_MIS);
    end
  end

  assign o_misaligned = mis_q;
`else
  assign o_misaligned = 1'b0;
`endif

  assign o_vld      = vld_q;
  assign o_rd_waddr = rd_waddr_q;
  assign o_rd_wen   = rd_wen_q;
  assign o_rd_wdata = rd_wdata_q;
  assign o_inst     = inst_q;
  assign o_pc       = pc_q;
  assign o_nxt_pc   = nxt_pc_q;
  assign o_break    = break_q;
  assign o_dmem_err = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, bubbles, loads/stores of every width,
// response latency, timeout, reset mid-access and the optional misalignment trap.
module tb_mem_stage;
  localparam logic [31:0] RST_INST = 32'h0000_0033;
  localparam int          TMO      = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld, mem_read, mem_write, rd_wen, brk;
  logic [2:0]  opsel;
  logic [31:0] res, wdata, inst, pc, nxt_pc;
  logic [4:0]  rd_waddr;
  logic        busy, o_vld, o_rd_wen, o_break, o_err, o_mis;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata, o_inst, o_pc, o_nxt_pc;

  int total = 0;
  int bad   = 0;

  logic        seen_req;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_mask;
  logic        s_wen;
  int          busy_n;

  mem_stage_if dif ();

  always #5 clk = ~clk;

  mem_stage #(.RST_INST(RST_INST), .TMO_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_mem_read(mem_read),
    .i_mem_write(mem_write), .i_opsel(opsel), .i_res(res), .i_wdata(wdata),
    .i_rd_waddr(rd_waddr), .i_rd_wen(rd_wen), .i_inst(inst), .i_pc(pc),
    .i_nxt_pc(nxt_pc), .i_break(brk), .dmem(dif.master), .o_data_busy(busy),
    .o_vld(o_vld), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen),
    .o_rd_wdata(o_rd_wdata), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_break(o_break), .o_dmem_err(o_err), .o_misaligned(o_mis)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one memory op (starting just after a negedge) and play the memory side:
  // ready pulses in cycle rdy_at, rvalid in cycle rv_at (cycle 0 is the IDLE cycle).
  // Returns just after the negedge following completion, with a bubble on the inputs.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_at, input int rv_at, input logic [31:0] rdata);
    int cyc;
    bit fin;
    vld = 1'b1; mem_read = rd; mem_write = wr; opsel = op; res = addr; wdata = wd;
    rd_waddr = 5'd9; rd_wen = 1'b1;
    busy_n = 0; seen_req = 1'b0; cyc = 0; fin = 1'b0;
    s_addr = '0; s_wdata = '0; s_mask = '0; s_wen = 1'b0;
    while (!fin && cyc < 200) begin
      dif.ready  = (cyc == rdy_at);
      dif.rvalid = (cyc == rv_at);
      dif.rdata  = (cyc == rv_at) ? rdata : 32'h0BAD_0BAD;
      #1;
      if (dif.req) begin
        seen_req = 1'b1; s_addr = dif.addr; s_wdata = dif.wdata;
        s_mask = dif.mask; s_wen = dif.wen;
      end
      if (busy) busy_n++;
      else fin = 1'b1;
      @(negedge clk);
      cyc++;
    end
    if (!fin) check("op_bound", 32'(fin), 32'd1);
    vld = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    dif.ready = 1'b0; dif.rvalid = 1'b0;
    #1;
  endtask

  initial begin
    vld = 0; mem_read = 0; mem_write = 0; rd_wen = 0; brk = 0; opsel = 3'b010;
    res = 0; wdata = 0; inst = 0; pc = 0; nxt_pc = 0; rd_waddr = 0;
    dif.ready = 0; dif.rvalid = 0; dif.rdata = 0;

    @(negedge clk);
    check("rst_vld", o_vld, 0);
    check("rst_inst", o_inst, RST_INST);
    check("rst_wdata", o_rd_wdata, 0);
    check("rst_req", dif.req, 0);
    check("rst_err", o_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU op then flushed bubble
    vld = 1; res = 32'h1234; rd_waddr = 5; rd_wen = 1; inst = 32'h0050_0293;
    pc = 32'h40; nxt_pc = 32'h44; brk = 1;
    #1 check("alu_busy0", busy, 0);
    @(negedge clk);
    check("alu_wdata", o_rd_wdata, 32'h1234);
    check("alu_wen", o_rd_wen, 1);
    check("alu_waddr", o_rd_waddr, 5);
    check("alu_vld", o_vld, 1);
    check("alu_pc", o_pc, 32'h40);
    check("alu_nxt", o_nxt_pc, 32'h44);
    check("alu_brk", o_break, 1);
    check("alu_busy1", busy, 0);
    vld = 0; res = 32'h55; brk = 0;
    @(negedge clk);
    check("bub_vld", o_vld, 0);
    check("bub_wen", o_rd_wen, 0);
    check("bub_wdata", o_rd_wdata, 32'h55);

    // LB 0x103, ready at REQ, rvalid one cycle later
    run_op(1, 0, 3'b000, 32'h103, 0, 1, 2, 32'h80FF_0000);
    check("lb_addr", s_addr, 32'h100);
    check("lb_wen", s_wen, 0);
    check("lb_busy", busy_n, 2);
    check("lb_data", o_rd_wdata, 32'hFFFF_FF80);
    check("lb_rdwen", o_rd_wen, 1);
    check("lb_waddr", o_rd_waddr, 9);

    // LHU with ready and rvalid together
    run_op(1, 0, 3'b101, 32'h2, 0, 1, 1, 32'hBEEF_0000);
    check("lhu_busy", busy_n, 1);
    check("lhu_addr", s_addr, 32'h0);
    check("lhu_data", o_rd_wdata, 32'h0000_BEEF);

    run_op(1, 0, 3'b001, 32'h10, 0, 1, 1, 32'h1234_8001);
    check("lh_data", o_rd_wdata, 32'hFFFF_8001);

    run_op(1, 0, 3'b100, 32'h21, 0, 2, 4, 32'h0000_C300);
    check("lbu_busy", busy_n, 4);
    check("lbu_data", o_rd_wdata, 32'h0000_00C3);

    run_op(1, 0, 3'b010, 32'h40, 0, 1, 2, 32'hDEAD_BEEF);
    check("lw_data", o_rd_wdata, 32'hDEAD_BEEF);

    // Stores
    run_op(0, 1, 3'b000, 32'h6, 32'h1234_56A5, 1, -1, 0);
    check("sb_mask", s_mask, 4'b0100);
    check("sb_wdata", s_wdata, 32'hA5A5_A5A5);
    check("sb_wen", s_wen, 1);
    check("sb_rdwen", o_rd_wen, 0);
    check("sb_busy", busy_n, 1);

    run_op(0, 1, 3'b001, 32'hA, 32'h1111_BEEF, 3, -1, 0);
    check("sh_mask", s_mask, 4'b1100);
    check("sh_wdata", s_wdata, 32'hBEEF_BEEF);
    check("sh_addr", s_addr, 32'h8);
    check("sh_busy", busy_n, 3);

    run_op(0, 1, 3'b010, 32'hC, 32'hCAFE_F00D, 1, -1, 0);
    check("sw_mask", s_mask, 4'hF);
    check("sw_wdata", s_wdata, 32'hCAFE_F00D);
    check("sw_rdwdata", o_rd_wdata, 32'hC);

    // Load never answered
    run_op(1, 0, 3'b010, 32'h80, 0, 1, -1, 0);
    check("tmo_busy", busy_n, TMO);
    check("tmo_err", o_err, 1);
    check("tmo_rdwen", o_rd_wen, 0);
    check("tmo_vld", o_vld, 1);
    res = 32'h77; dif.rvalid = 1; dif.rdata = 32'hFFFF_FFFF;
    #1 check("late_busy", busy, 0);
    check("late_req", dif.req, 0);
    @(negedge clk);
    dif.rvalid = 0;
    check("tmo_pulse", o_err, 0);
    check("late_wdata", o_rd_wdata, 32'h77);

    // Misaligned word load
    run_op(1, 0, 3'b010, 32'h2, 0, 1, 2, 32'h1122_3344);
`ifdef MEM_MISALIGN_CHK_EN
    check("mis_busy", busy_n, 1);
    check("mis_noreq", seen_req, 0);
    check("mis_flag", o_mis, 1);
    check("mis_rdwen", o_rd_wen, 0);
`else
    check("mis_busy", busy_n, 2);
    check("mis_addr", s_addr, 32'h0);
    check("mis_data", o_rd_wdata, 32'h1122_3344);
    check("mis_flag", o_mis, 0);
`endif

    // Reset while a load waits for data
    vld = 1; rd_wen = 1; inst = 32'h1111_1111; res = 32'h9;
    @(negedge clk);
    check("pre_vld", o_vld, 1);
    mem_read = 1; opsel = 3'b010; res = 32'h200;
    @(negedge clk);
    #1 check("rr_req", dif.req, 1);
    dif.ready = 1;
    @(negedge clk);
    dif.ready = 0;
    #1 check("rr_wait", dif.req, 0);
    rst_n = 0;
    #1;
    check("rr_req0", dif.req, 0);
    check("rr_vld", o_vld, 0);
    check("rr_inst", o_inst, RST_INST);
    vld = 0; mem_read = 0; res = 32'h3; dif.rvalid = 1; dif.rdata = 32'h5555_5555;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    dif.rvalid = 0;
    check("rr_busy", busy, 0);
    check("rr_wdata", o_rd_wdata, 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
